// File: rtl/gpio_param_writer.sv
// rtl/gpio_param_writer.sv - host-to-fabric parameter writer over a toggle-handshaked GPIO pair
// Optional shadow bank with commit word: define GPIO_PARAM_SHADOW_EN.
module gpio_param_writer #(
  parameter int GPIO_WIDTH = 32,
  parameter int PARAM_COUNT = 16,
  parameter logic [PARAM_COUNT*GPIO_WIDTH-1:0] PARAM_RESET = '0
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [GPIO_WIDTH-1:0]             GP_IN,
  input  logic [3:0]                        SET,
  output logic [GPIO_WIDTH-1:0]             GP_OUT,
  output logic [PARAM_COUNT*GPIO_WIDTH-1:0] PARAMS_DATA,
  output logic                              UPDATE,
  output logic [3:0]                        UPDATE_IDX
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LO   = 2'b01,
    S_HI   = 2'b10
  } state_t;

  localparam logic [1:0] T_HDR    = 2'b00;
  localparam logic [1:0] T_LO     = 2'b01;
  localparam logic [1:0] T_HI     = 2'b10;
  localparam logic [1:0] T_COMMIT = 2'b11;

  logic [GPIO_WIDTH-1:0] sync1, sync2;
  logic                  prev_tgl;
  logic                  armed;

  state_t      state, state_n;
  logic        err, err_n;
  logic        ack, ack_n;
  logic [3:0]  idx, idx_n;
  logic [15:0] echo, echo_n;
  logic [15:0] stage, stage_n;
  logic        upd, upd_n;
  logic [3:0]  upd_idx, upd_idx_n;
  logic        wr_en;

  logic [GPIO_WIDTH-1:0] bank [PARAM_COUNT];

  // The synchronizer runs through reset so a TGL held across reset is already
  // settled when the arming cycle samples it.
  always_ff @(posedge CLK) begin
    sync1    <= GP_IN;
    sync2    <= sync1;
    prev_tgl <= sync2[31];
  end

  logic        evt;
  logic        w_tgl;
  logic [1:0]  w_type;
  logic [3:0]  w_set;
  logic [3:0]  w_idx;
  logic [15:0] w_pay;
  logic        idx_oor;
  logic        unused_bits;

  assign evt         = armed && (sync2[31] != prev_tgl);
  assign w_tgl       = sync2[31];
  assign w_type      = sync2[30:29];
  assign w_set       = sync2[27:24];
  assign w_idx       = sync2[3:0];
  assign w_pay       = sync2[15:0];
  assign idx_oor     = (32'(w_idx) >= 32'(PARAM_COUNT));
  assign unused_bits = ^{sync2[28], sync2[23:16]};

`ifdef GPIO_PARAM_SHADOW_EN
  logic                  commit_en;
  logic [GPIO_WIDTH-1:0] shadow [PARAM_COUNT];
`endif

  always_comb begin
    state_n   = state;
    err_n     = err;
    ack_n     = ack;
    idx_n     = idx;
    echo_n    = echo;
    stage_n   = stage;
    upd_n     = 1'b0;
    upd_idx_n = upd_idx;
    wr_en     = 1'b0;
`ifdef GPIO_PARAM_SHADOW_EN
    commit_en = 1'b0;
`endif
    if (evt) begin
      ack_n  = w_tgl;
      echo_n = w_pay;
      case (state)
        S_IDLE: begin
          if (w_type == T_HDR) begin
            if (w_set != SET) begin
              err_n = 1'b0;
            end else if (idx_oor) begin
              err_n = 1'b1;
            end else begin
              idx_n   = w_idx;
              err_n   = 1'b0;
              state_n = S_LO;
            end
          end else if (w_type == T_COMMIT) begin
`ifdef GPIO_PARAM_SHADOW_EN
            if (w_set == SET) begin
              commit_en = 1'b1;
              upd_n     = 1'b1;
              upd_idx_n = 4'hF;
            end
`else
            err_n = 1'b1;
`endif
          end else begin
            err_n = 1'b1;
          end
        end
        S_LO: begin
          if (w_type == T_LO) begin
            stage_n = w_pay;
            state_n = S_HI;
          end else begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end
        end
        S_HI: begin
          state_n = S_IDLE;
          if (w_type == T_HI) begin
            wr_en = 1'b1;
`ifndef GPIO_PARAM_SHADOW_EN
            upd_n     = 1'b1;
            upd_idx_n = idx;
`endif
          end else begin
            err_n = 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      err     <= 1'b0;
      ack     <= 1'b0;
      idx     <= 4'd0;
      echo    <= 16'd0;
      stage   <= 16'd0;
      upd     <= 1'b0;
      upd_idx <= 4'd0;
      armed   <= 1'b0;
    end else begin
      state   <= state_n;
      err     <= err_n;
      ack     <= ack_n;
      idx     <= idx_n;
      echo    <= echo_n;
      stage   <= stage_n;
      upd     <= upd_n;
      upd_idx <= upd_idx_n;
      armed   <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < PARAM_COUNT; i++) begin
        bank[i] <= PARAM_RESET[i*GPIO_WIDTH +: GPIO_WIDTH];
      end
    end else begin
`ifdef GPIO_PARAM_SHADOW_EN
      if (commit_en) begin
        for (int i = 0; i < PARAM_COUNT; i++) begin
          bank[i] <= shadow[i];
        end
      end
`else
      for (int i = 0; i < PARAM_COUNT; i++) begin
        if (wr_en && idx == 4'(i)) bank[i] <= {w_pay, stage};
      end
`endif
    end
  end

`ifdef GPIO_PARAM_SHADOW_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < PARAM_COUNT; i++) begin
        shadow[i] <= PARAM_RESET[i*GPIO_WIDTH +: GPIO_WIDTH];
      end
    end else begin
      for (int i = 0; i < PARAM_COUNT; i++) begin
        if (wr_en && idx == 4'(i)) shadow[i] <= {w_pay, stage};
      end
    end
  end
`endif

  for (genvar g = 0; g < PARAM_COUNT; g++) begin : g_flat
    assign PARAMS_DATA[g*GPIO_WIDTH +: GPIO_WIDTH] = bank[g];
  end

  assign GP_OUT     = {ack, err, state, 8'h00, idx, echo};
  assign UPDATE     = upd;
  assign UPDATE_IDX = upd_idx;

endmodule

// File: tb/tb_gpio_param_writer.sv
// tb/tb_gpio_param_writer.sv - randomized self-checking bench for gpio_param_writer against a transaction model
module tb_gpio_param_writer;
  localparam int PC = 8;

  logic            CLK = 1'b0;
  logic            RST;
  logic [31:0]     GP_IN;
  logic [3:0]      SET;
  logic [31:0]     GP_OUT;
  logic [PC*32-1:0] PARAMS_DATA;
  logic            UPDATE;
  logic [3:0]      UPDATE_IDX;

  always #5 CLK = ~CLK;

  gpio_param_writer #(.GPIO_WIDTH(32), .PARAM_COUNT(PC)) dut (
    .CLK(CLK), .RST(RST), .GP_IN(GP_IN), .SET(SET), .GP_OUT(GP_OUT),
    .PARAMS_DATA(PARAMS_DATA), .UPDATE(UPDATE), .UPDATE_IDX(UPDATE_IDX)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level view of what the host has told the block so far.
  logic [31:0] m_bank [PC];
  logic [31:0] m_shadow [PC];
  int          m_phase;
  logic        m_err, m_ack;
  logic [3:0]  m_idx;
  logic [15:0] m_echo, m_low;
  logic        e_upd;
  logic [3:0]  e_upd_idx;
  bit          chk_en = 0;
  logic        cur_tgl;
  int          upd_cnt = 0;

  function automatic logic [PC*32-1:0] m_flat();
    logic [PC*32-1:0] f;
    for (int i = 0; i < PC; i++) f[i*32 +: 32] = m_bank[i];
    return f;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < PC; i++) begin
      m_bank[i] = 32'd0;
      m_shadow[i] = 32'd0;
    end
    m_phase = 0; m_err = 0; m_ack = 0; m_idx = 0; m_echo = 0; m_low = 0;
    e_upd = 0; e_upd_idx = 0;
  endtask

  task automatic model_word(input logic [31:0] w);
    logic [1:0] typ;
    typ = w[30:29];
    m_ack = w[31];
    m_echo = w[15:0];
    if (m_phase == 0) begin
      if (typ == 2'b00) begin
        if (w[27:24] != SET) m_err = 0;
        else if (int'(w[3:0]) >= PC) m_err = 1;
        else begin m_idx = w[3:0]; m_err = 0; m_phase = 1; end
      end else if (typ == 2'b11) begin
`ifdef GPIO_PARAM_SHADOW_EN
        if (w[27:24] == SET) begin
          for (int i = 0; i < PC; i++) m_bank[i] = m_shadow[i];
          e_upd = 1; e_upd_idx = 4'hF;
        end
`else
        m_err = 1;
`endif
      end else m_err = 1;
    end else if (m_phase == 1) begin
      if (typ == 2'b01) begin m_low = w[15:0]; m_phase = 2; end
      else begin m_err = 1; m_phase = 0; end
    end else begin
      m_phase = 0;
      if (typ == 2'b10) begin
`ifdef GPIO_PARAM_SHADOW_EN
        m_shadow[m_idx] = {w[15:0], m_low};
`else
        m_bank[m_idx] = {w[15:0], m_low};
        e_upd = 1; e_upd_idx = m_idx;
`endif
      end else m_err = 1;
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("gp_out", 256'(GP_OUT), 256'({m_ack, m_err, 2'(m_phase), 8'h00, m_idx, m_echo}));
      check("params_data", 256'(PARAMS_DATA), 256'(m_flat()));
      check("update", 256'(UPDATE), 256'(e_upd));
      check("update_idx", 256'(UPDATE_IDX), 256'(e_upd_idx));
      if (UPDATE) upd_cnt++;
    end
  end

  // Host side: toggle TGL, then the result is visible after the third edge.
  task automatic send(input logic [1:0] typ, input logic [3:0] set, input logic [3:0] idx,
                      input logic [15:0] pay);
    logic [31:0] w;
    w = $urandom;
    cur_tgl = ~cur_tgl;
    w[31] = cur_tgl;
    w[30:29] = typ;
    if (typ == 2'b00 || typ == 2'b11) begin
      w[27:24] = set;
      w[3:0] = idx;
    end else w[15:0] = pay;
    @(posedge CLK); #1 GP_IN = w;
    repeat (3) @(posedge CLK);
    #1 model_word(w);
    @(posedge CLK); #1 e_upd = 0;
    repeat ($urandom_range(0, 2)) @(posedge CLK);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1 RST = 1;
    @(posedge CLK); #1 model_reset();
    repeat (3) @(posedge CLK);
    #1 RST = 0;
    repeat (2) @(posedge CLK);
  endtask

  int n0;

  initial begin
    SET = 4'd3;
    RST = 1;
    cur_tgl = 1;
    GP_IN = 32'h8000_0000;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 chk_en = 1;
    repeat (3) @(posedge CLK);
    #1 RST = 0;
    repeat (6) @(posedge CLK);
    #1;
    check("reset_gp_out", 256'(GP_OUT), 256'd0);
    check("reset_params", 256'(PARAMS_DATA), 256'd0);
    check("reset_no_update", 256'(upd_cnt), 256'd0);

    n0 = upd_cnt;
    send(2'b00, 4'd3, 4'd5, 16'h0);
    send(2'b01, 4'd0, 4'd0, 16'hBEEF);
    send(2'b10, 4'd0, 4'd0, 16'hDEAD);
`ifdef GPIO_PARAM_SHADOW_EN
    check("shadow_hidden", 256'(PARAMS_DATA[5*32 +: 32]), 256'd0);
    send(2'b00, 4'd3, 4'd0, 16'h0); send(2'b01, 4'd0, 4'd0, 16'h1111); send(2'b10, 4'd0, 4'd0, 16'h2222);
    send(2'b00, 4'd3, 4'd1, 16'h0); send(2'b01, 4'd0, 4'd0, 16'h3333); send(2'b10, 4'd0, 4'd0, 16'h4444);
    check("shadow_no_update", 256'(upd_cnt - n0), 256'd0);
    send(2'b11, 4'd3, 4'd0, 16'h0);
    check("commit_p0", 256'(PARAMS_DATA[0 +: 32]), 256'h2222_1111);
    check("commit_p1", 256'(PARAMS_DATA[32 +: 32]), 256'h4444_3333);
`endif
    check("p5_value", 256'(PARAMS_DATA[5*32 +: 32]), 256'hDEAD_BEEF);
    check("p5_one_pulse", 256'(upd_cnt - n0), 256'd1);

    send(2'b00, 4'd3, 4'd15, 16'h0);
    check("oor_err", 256'(GP_OUT[30:28]), 256'b100);
    send(2'b00, 4'd3, 4'd2, 16'h0);
    check("hdr_clears_err", 256'(GP_OUT[30:28]), 256'b001);
    send(2'b01, 4'd0, 4'd0, 16'h5678);
    send(2'b10, 4'd0, 4'd0, 16'h1234);

    n0 = upd_cnt;
    send(2'b00, 4'd2, 4'd1, 16'h0);
    check("set_mismatch_idle", 256'(GP_OUT[30:28]), 256'b000);
    send(2'b01, 4'd0, 4'd0, 16'hAAAA);
    send(2'b10, 4'd0, 4'd0, 16'hBBBB);
    check("set_mismatch_err", 256'(GP_OUT[30]), 256'd1);
    check("set_mismatch_nowrite", 256'(upd_cnt - n0), 256'd0);

    send(2'b00, 4'd3, 4'd6, 16'h0);
    send(2'b01, 4'd0, 4'd0, 16'h1234);
    do_reset();
    send(2'b10, 4'd0, 4'd0, 16'h9999);
    check("midreset_err", 256'(GP_OUT[30]), 256'd1);
    check("midreset_bank", 256'(PARAMS_DATA), 256'd0);

    repeat (60) begin
      if ($urandom_range(0, 9) < 6) begin
        send(2'b00, 4'd3, 4'($urandom_range(0, PC - 1)), 16'h0);
        send(2'b01, 4'd0, 4'd0, 16'($urandom));
        send(2'b10, 4'd0, 4'd0, 16'($urandom));
      end else begin
        send(2'($urandom), ($urandom_range(0, 1) == 0) ? 4'd3 : 4'($urandom),
             4'($urandom), 16'($urandom));
      end
    end
`ifdef GPIO_PARAM_SHADOW_EN
    send(2'b11, 4'd3, 4'd0, 16'h0);
`endif
    repeat (4) @(posedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
